// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous input in fast-clock cycles.
// Results are published with a valid/ack handshake; timeout and overrun flags are sticky.
module clock_period_meter #(
    parameter int          COUNT_WIDTH = 20,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 20'hFFFFF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   div_clock,
    input  logic                   ack,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic                   valid,
    output logic                   overrun,
    output logic                   timeout,
    output logic                   locked,
    output logic                   edge_pulse
);

    localparam logic [COUNT_WIDTH-1:0] TO_VAL = COUNT_WIDTH'(TIMEOUT);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] hi_lat;
    logic                   arm;
    logic                   publish;
    logic                   expire;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            s_d        <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], div_clock};
            s_d        <= s;
            edge_pulse <= rise;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise always wins over an expiring counter, so a period of exactly TIMEOUT still publishes.
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        publish = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    arm     = 1'b1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    publish = 1'b1;
                end else if (cnt == TO_VAL) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            hi_lat <= '0;
        end else begin
            if (rise) begin
                cnt <= COUNT_WIDTH'(1);
            end else if (state_q == IDLE || expire) begin
                cnt <= '0;
            end else if (cnt != TO_VAL) begin
                cnt <= cnt + 1'b1;
            end
            if (fall) begin
                hi_lat <= cnt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
            locked  <= 1'b0;
        end else begin
            if (arm) begin
                timeout <= 1'b0;
            end else if (expire) begin
                timeout <= 1'b1;
            end
            if (publish) begin
                locked <= 1'b1;
            end else if (expire) begin
                locked <= 1'b0;
            end
        end
    end

    // An ack landing in the publish cycle consumes the old result, so the overwrite is not an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else if (publish) begin
            period    <= cnt;
            high_time <= hi_lat;
            valid     <= 1'b1;
            if (valid) begin
                overrun <= ~ack;
            end
        end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: duty patterns, handshake corners, timeout and mid-run reset.
module tb_clock_period_meter;

    localparam int CW = 20;

    logic          clock;
    logic          reset;
    logic          div_clock;
    logic          ack;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          overrun;
    logic          timeout;
    logic          locked;
    logic          edge_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic gen_on    = 1'b0;
    int   gen_hi    = 4;
    int   gen_lo    = 4;

    clock_period_meter #(
        .COUNT_WIDTH (CW),
        .SYNC_STAGES (2),
        .TIMEOUT     (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .div_clock  (div_clock),
        .ack        (ack),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .overrun    (overrun),
        .timeout    (timeout),
        .locked     (locked),
        .edge_pulse (edge_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Waveform generator: parameters are read at phase boundaries on the falling clock edge.
    initial begin
        div_clock = 1'b0;
        forever begin
            if (gen_on) begin
                div_clock = 1'b1;
                repeat (gen_hi) @(negedge clock);
                div_clock = 1'b0;
                repeat (gen_lo) @(negedge clock);
            end else begin
                div_clock = 1'b0;
                @(negedge clock);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_gen(input logic on, input int hi, input int lo);
        #1;
        gen_on = on;
        gen_hi = hi;
        gen_lo = lo;
    endtask

    task automatic wait_pulse(input string tag);
        int i;
        i = 0;
        @(negedge clock);
        while (!edge_pulse && i < 100) begin
            @(negedge clock);
            i++;
        end
        check(tag, edge_pulse, 1);
    endtask

    task automatic do_ack;
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        ack   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", valid, 0);
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;

        // 4 high / 4 low: first rise only arms
        set_gen(1, 4, 4);
        wait_pulse("p1_seen");
        check("p1_valid", valid, 0);
        check("p1_locked", locked, 0);
        wait_pulse("p2_seen");
        check("p2_period", period, 8);
        check("p2_high", high_time, 4);
        check("p2_valid", valid, 1);
        check("p2_locked", locked, 1);
        set_gen(1, 3, 7);
        do_ack();
        check("p2_pulse_width", edge_pulse, 0);
        check("p2_ack_valid", valid, 0);

        // 3 high / 7 low with every result acknowledged
        wait_pulse("p3_seen");
        do_ack();
        wait_pulse("p4_seen");
        check("p4_period", period, 10);
        check("p4_high", high_time, 3);
        check("p4_overrun", overrun, 0);
        do_ack();
        wait_pulse("p5_seen");
        check("p5_period", period, 10);
        check("p5_high", high_time, 3);
        check("p5_overrun", overrun, 0);
        set_gen(1, 4, 4);
        do_ack();

        // Two unacknowledged periods of 8
        wait_pulse("p6_seen");
        do_ack();
        wait_pulse("p7_seen");
        check("p7_valid", valid, 1);
        check("p7_overrun", overrun, 0);
        wait_pulse("p8_seen");
        check("p8_period", period, 8);
        check("p8_overrun", overrun, 1);
        do_ack();
        check("p8_ack_valid", valid, 0);
        check("p8_ack_overrun", overrun, 0);

        // ack in the publish cycle of a result that would otherwise overrun
        wait_pulse("p9_seen");
        wait_pulse("p10_seen");
        check("p10_overrun", overrun, 1);
        repeat (7) @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        check("p11_pulse", edge_pulse, 1);
        check("p11_valid", valid, 1);
        check("p11_overrun", overrun, 0);
        check("p11_period", period, 8);

        // Stop the input: timeout exactly 20 cycles after the last rise cycle
        set_gen(0, 4, 4);
        repeat (19) @(negedge clock);
        check("to_early", timeout, 0);
        check("to_early_locked", locked, 1);
        @(negedge clock);
        check("to_flag", timeout, 1);
        check("to_locked", locked, 0);
        check("to_valid_kept", valid, 1);
        check("to_period_kept", period, 8);
        check("to_overrun_kept", overrun, 0);
        do_ack();
        set_gen(1, 4, 4);
        wait_pulse("r1_seen");
        check("r1_timeout", timeout, 0);
        check("r1_valid", valid, 0);
        check("r1_locked", locked, 0);
        wait_pulse("r2_seen");
        check("r2_period", period, 8);
        check("r2_high", high_time, 4);
        check("r2_valid", valid, 1);
        check("r2_locked", locked, 1);

        // Asynchronous reset during the synchronized high phase with a result pending
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ar_valid", valid, 0);
        check("ar_period", period, 0);
        check("ar_high", high_time, 0);
        check("ar_locked", locked, 0);
        check("ar_overrun", overrun, 0);
        check("ar_timeout", timeout, 0);
        check("ar_pulse", edge_pulse, 0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        wait_pulse("a1_seen");
        check("a1_valid", valid, 0);
        check("a1_locked", locked, 0);
        wait_pulse("a2_seen");
        check("a2_period", period, 8);
        check("a2_high", high_time, 4);
        check("a2_valid", valid, 1);
        check("a2_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
